// File: rtl/apu_voice_engine.sv
// Multi-voice square-wave audio engine with per-voice decaying envelopes, OR-mixed to one bit.
// Define NOISE_EN to build the LFSR noise-burst channel; without it sfx_trig is ignored.
module apu_voice_engine #(
    parameter int NUM_VOICES = 4,
    parameter int PERIOD_W   = 9,
    parameter int ENV_W      = 5,
    parameter int ENV_SCALE  = 3,
    localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_tick,
    input  logic                  frame_tick,
    input  logic [9:0]            hpos,
    input  logic                  wr_en,
    input  logic [VOICE_W-1:0]    wr_voice,
    input  logic [PERIOD_W-1:0]   wr_period,
    input  logic [NUM_VOICES-1:0] voice_mask,
    input  logic                  sfx_trig,
    output logic                  audio_out,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  noise_active
);

    localparam int CMP_W = (ENV_W + ENV_SCALE > 10) ? (ENV_W + ENV_SCALE) : 10;
    localparam logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}};

    logic [PERIOD_W-1:0]   period_q  [NUM_VOICES];
    logic [PERIOD_W-1:0]   counter_q [NUM_VOICES];
    logic [ENV_W-1:0]      env_q     [NUM_VOICES];
    logic [NUM_VOICES-1:0] phase_q;
    logic [NUM_VOICES-1:0] voice_audible;
    logic                  noise_audible;
    logic [CMP_W-1:0]      hpos_ext;

    assign hpos_ext = CMP_W'(hpos);

    // The envelope doubles as a pulse width: louder notes stay high for more of the line.
    function automatic logic env_gate(input logic [ENV_W-1:0] env, input logic [CMP_W-1:0] h);
        logic [CMP_W-1:0] limit;
        limit = CMP_W'(env) << ENV_SCALE;
        return h < limit;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                period_q[i]  <= '0;
                counter_q[i] <= '0;
                env_q[i]     <= '0;
            end
            phase_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                // A note-on overrides any tick landing on the same voice in the same cycle.
                if (wr_en && (wr_voice == VOICE_W'(i))) begin
                    period_q[i]  <= wr_period;
                    counter_q[i] <= '0;
                    phase_q[i]   <= 1'b0;
                    env_q[i]     <= ENV_MAX;
                end else begin
                    if (line_tick) begin
                        if (counter_q[i] == period_q[i]) begin
                            counter_q[i] <= '0;
                            phase_q[i]   <= ~phase_q[i];
                        end else begin
                            counter_q[i] <= counter_q[i] + PERIOD_W'(1);
                        end
                    end
                    if (frame_tick && (env_q[i] != '0)) begin
                        env_q[i] <= env_q[i] - ENV_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        voice_active  = '0;
        voice_audible = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_active[i]  = (env_q[i] != '0);
            voice_audible[i] = phase_q[i] && (period_q[i] != '0) && voice_active[i]
                               && voice_mask[i] && env_gate(env_q[i], hpos_ext);
        end
    end

`ifdef NOISE_EN
    logic [12:0]      lfsr_q;
    logic [ENV_W-1:0] noise_env_q;
    logic             sfx_prev_q;
    logic             sfx_rise;
    logic             lfsr_fb;

    assign sfx_rise = sfx_trig & ~sfx_prev_q;
    assign lfsr_fb  = lfsr_q[12] ^ lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= 13'h0001;
            noise_env_q <= '0;
            sfx_prev_q  <= 1'b0;
        end else begin
            sfx_prev_q <= sfx_trig;
            // The LFSR freezes between bursts so each burst continues the sequence.
            if (line_tick && (noise_env_q != '0)) begin
                lfsr_q <= {lfsr_q[11:0], lfsr_fb};
            end
            if (sfx_rise) begin
                noise_env_q <= ENV_MAX;
            end else if (frame_tick && (noise_env_q != '0)) begin
                noise_env_q <= noise_env_q - ENV_W'(1);
            end
        end
    end

    assign noise_active  = (noise_env_q != '0);
    assign noise_audible = lfsr_q[0] && noise_active && env_gate(noise_env_q, hpos_ext);
`else
    logic unused_sfx_trig;
    assign unused_sfx_trig = sfx_trig;
    assign noise_active    = 1'b0;
    assign noise_audible   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out <= 1'b0;
        end else begin
            audio_out <= (|voice_audible) | noise_audible;
        end
    end

endmodule

// File: tb/tb_apu_voice_engine.sv
// Randomized and directed checks of apu_voice_engine against a tick-counting reference model.
// NUM_VOICES=5 so that wr_voice can carry an out-of-range index (5..7).
module tb_apu_voice_engine;

    localparam int NV = 5;
    localparam int VW = 3;

    logic          clk;
    logic          rst_n;
    logic          line_tick;
    logic          frame_tick;
    logic [9:0]    hpos;
    logic          wr_en;
    logic [VW-1:0] wr_voice;
    logic [8:0]    wr_period;
    logic [NV-1:0] voice_mask;
    logic          sfx_trig;
    logic          audio_out;
    logic [NV-1:0] voice_active;
    logic          noise_active;

    apu_voice_engine #(
        .NUM_VOICES(NV), .PERIOD_W(9), .ENV_W(5), .ENV_SCALE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line_tick(line_tick), .frame_tick(frame_tick),
        .hpos(hpos), .wr_en(wr_en), .wr_voice(wr_voice), .wr_period(wr_period),
        .voice_mask(voice_mask), .sfx_trig(sfx_trig), .audio_out(audio_out),
        .voice_active(voice_active), .noise_active(noise_active)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and counters
    logic exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each voice is described by its period and the number of
    // line/frame ticks seen since its last note-on.
    int          m_period [NV];
    int          m_lines  [NV];
    int          m_frames [NV];
    int          n_frames;
    logic [12:0] n_lfsr;
    logic        n_prev;

    function automatic int env_of(input int frames);
        return (frames >= 31) ? 0 : 31 - frames;
    endfunction

    function automatic logic [12:0] lfsr_next(input logic [12:0] l);
        return {l[11:0], l[12] ^ l[11] ^ l[10] ^ l[7]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_period[i] = 0;
            m_lines[i]  = 0;
            m_frames[i] = 31;
        end
        n_frames = 31;
        n_lfsr   = 13'h0001;
        n_prev   = 1'b0;
    endtask

    function automatic logic model_audio(input logic [9:0] hp, input logic [NV-1:0] mask);
        logic a;
        int   e;
        a = 1'b0;
        for (int i = 0; i < NV; i++) begin
            e = env_of(m_frames[i]);
            if (m_period[i] != 0 && ((m_lines[i] / (m_period[i] + 1)) % 2) == 1
                && e > 0 && mask[i] && int'(hp) < e * 8)
                a = 1'b1;
        end
`ifdef NOISE_EN
        e = env_of(n_frames);
        if (n_lfsr[0] && e > 0 && int'(hp) < e * 8)
            a = 1'b1;
`endif
        return a;
    endfunction

    function automatic logic [NV-1:0] model_active();
        logic [NV-1:0] v;
        v = '0;
        for (int i = 0; i < NV; i++) v[i] = (env_of(m_frames[i]) > 0);
        return v;
    endfunction

    function automatic logic model_noise_active();
`ifdef NOISE_EN
        return env_of(n_frames) > 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_update(input logic lt, input logic ft, input logic we,
                                input logic [VW-1:0] wv, input logic [8:0] wp, input logic sfx);
        for (int i = 0; i < NV; i++) begin
            if (we && int'(wv) == i) begin
                m_period[i] = int'(wp);
                m_lines[i]  = 0;
                m_frames[i] = 0;
            end else begin
                if (lt) m_lines[i]++;
                if (ft && m_frames[i] < 31) m_frames[i]++;
            end
        end
`ifdef NOISE_EN
        if (lt && env_of(n_frames) > 0) n_lfsr = lfsr_next(n_lfsr);
        if (sfx && !n_prev) n_frames = 0;
        else if (ft && n_frames < 31) n_frames++;
        n_prev = sfx;
`endif
    endtask

    // Driver: apply one cycle of inputs, advance the model, check after the edge.
    task automatic drive(input logic lt, input logic ft, input logic [9:0] hp,
                         input logic we, input logic [VW-1:0] wv, input logic [8:0] wp,
                         input logic [NV-1:0] mask, input logic sfx);
        line_tick  = lt;
        frame_tick = ft;
        hpos       = hp;
        wr_en      = we;
        wr_voice   = wv;
        wr_period  = wp;
        voice_mask = mask;
        sfx_trig   = sfx;
        exp_q.push_back(model_audio(hp, mask));
        model_update(lt, ft, we, wv, wp, sfx);
        @(posedge clk);
        #1;
        check("audio_out", audio_out, exp_q.pop_front());
        check("voice_active", voice_active, model_active());
        check("noise_active", noise_active, model_noise_active());
    endtask

    initial begin
        rst_n = 1'b0;
        line_tick = 0; frame_tick = 0; hpos = '0; wr_en = 0;
        wr_voice = '0; wr_period = '0; voice_mask = '1; sfx_trig = 0;
        model_reset();
        #2;
        check("rst_audio", audio_out, 0);
        check("rst_voice_active", voice_active, 0);
        check("rst_noise_active", noise_active, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Voice 0 period 2 with a line tick every cycle: 3 lines per half-wave
        drive(1, 0, 0, 1, 0, 2, '1, 0);
        for (int k = 0; k < 12; k++) drive(1, 0, 0, 0, 0, 0, '1, 0);

        // Voice 1 decays to silence over 31 frames
        drive(0, 0, 0, 1, 1, 5, '1, 0);
        for (int k = 0; k < 31; k++) drive(k % 2 == 0, 1, 0, 0, 0, 0, '1, 0);
        check("v1_decayed", voice_active[1], 0);

        // hpos gating boundaries; note-on coincides with a frame tick
        drive(0, 1, 0, 1, 0, 1, 5'b00001, 0);
        drive(1, 0, 0, 0, 0, 0, 5'b00001, 0);
        drive(1, 0, 0, 0, 0, 0, 5'b00001, 0);
        drive(0, 0, 247, 0, 0, 0, 5'b00001, 0);
        check("hpos247_env31", audio_out, 1);
        drive(0, 0, 248, 0, 0, 0, 5'b00001, 0);
        check("hpos248_env31", audio_out, 0);
        drive(0, 1, 0, 0, 0, 0, 5'b00001, 0);
        drive(0, 0, 239, 0, 0, 0, 5'b00001, 0);
        check("hpos239_env30", audio_out, 1);
        drive(0, 0, 240, 0, 0, 0, 5'b00001, 0);
        check("hpos240_env30", audio_out, 0);

        // Out-of-range voice index is ignored
        drive(0, 0, 0, 1, 5, 3, 5'b00001, 0);
        check("oor_write_active", voice_active, 5'b00001);
        drive(0, 0, 0, 1, 7, 0, 5'b00001, 0);

        // Noise burst: rise, hold, retrigger mid-burst
        drive(0, 0, 0, 0, 0, 0, '1, 1);
        drive(1, 0, 0, 0, 0, 0, '1, 1);
        for (int k = 0; k < 8; k++) drive(1, 1, 10, 0, 0, 0, '1, 1);
        drive(1, 0, 0, 0, 0, 0, '1, 0);
        drive(1, 1, 0, 0, 0, 0, '1, 1);
        for (int k = 0; k < 6; k++) drive(1, 0, 0, 0, 0, 0, '1, 1);

        // Randomized traffic
        for (int k = 0; k < 2500; k++) begin
            logic [9:0] hp;
            logic       sfx;
            hp  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 260));
            sfx = ($urandom_range(0, 15) == 0) ? ~sfx_trig : sfx_trig;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, hp,
                  $urandom_range(0, 7) == 0, VW'($urandom_range(0, 7)),
                  9'($urandom_range(0, 6)), NV'($urandom), sfx);
        end

        // Reset mid-note
        drive(0, 0, 0, 1, 2, 1, '1, 0);
        drive(1, 0, 0, 0, 0, 0, '1, 0);
        drive(1, 0, 0, 0, 0, 0, '1, 0);
        drive(0, 0, 0, 0, 0, 0, '1, 0);
        check("pre_reset_audio", audio_out, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_audio", audio_out, 0);
        check("async_rst_voice_active", voice_active, 0);
        check("async_rst_noise_active", noise_active, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, '1, 1);
        for (int k = 0; k < 20; k++) drive(1, k % 4 == 0, 5, 0, 0, 0, '1, 1);
        drive(1, 0, 0, 1, 3, 4, '1, 0);
        for (int k = 0; k < 20; k++) drive(1, 0, 0, 0, 0, 0, '1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
